// File: rtl/irrigation_timer_mmss.sv
// irrigation_timer_mmss
//   Four-digit BCD mm:ss timer with an internal one-second prescaler.
//   It counts down from a loaded target to 00:00, or up from 00:00 to
//   the target. It supports run, pause and resume, and it raises a
//   one-cycle pulse when the count completes.
//
// Ports
//   clk       system clock, rising edge
//   clear     synchronous active-high reset
//   load      capture sanitised preset into target (IDLE/DONE only)
//   preset    packed BCD {min_t, min_u, sec_t, sec_u}
//   mode      0 = count down, 1 = count up (latched on fresh start)
//   start     fresh start from IDLE/DONE, resume from PAUSE
//   pause     suspend counting (RUN only)
//   digits    current value, packed BCD
//   running   high in RUN
//   paused    high in PAUSE
//   expired   high in DONE
//   done      one-cycle pulse on entry to DONE
//   sec_tick  one-cycle pulse on each applied one-second step
module irrigation_timer_mmss #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int MIN_TENS_MAX = 5
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        mode,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] digits,
    output logic        running,
    output logic        paused,
    output logic        expired,
    output logic        done,
    output logic        sec_tick
);

    localparam int             PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]     MT_MAX     = 4'(MIN_TENS_MAX);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   target_q, target_d;
    logic [15:0]   digits_d;
    logic          mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_d, tick_d;
    logic [15:0]   terminal, stepped;

    function automatic logic [3:0] clamp4(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [15:0] step_down(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (d[3:0] != 4'd0) r[3:0] = d[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (d[7:4] != 4'd0) r[7:4] = d[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd5;
                if (d[11:8] != 4'd0) r[11:8] = d[11:8] - 4'd1;
                else begin
                    r[11:8] = 4'd9;
                    if (d[15:12] != 4'd0) r[15:12] = d[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] step_up(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (d[3:0] != 4'd9) r[3:0] = d[3:0] + 4'd1;
        else begin
            r[3:0] = 4'd0;
            if (d[7:4] != 4'd5) r[7:4] = d[7:4] + 4'd1;
            else begin
                r[7:4] = 4'd0;
                if (d[11:8] != 4'd9) r[11:8] = d[11:8] + 4'd1;
                else begin
                    r[11:8] = 4'd0;
                    // Tens of minutes saturate rather than wrap.
                    if (d[15:12] != MT_MAX) r[15:12] = d[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign terminal = mode_q ? target_q : 16'h0000;
    assign stepped  = mode_q ? step_up(digits) : step_down(digits);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        digits_d = digits;
        mode_d   = mode_q;
        presc_d  = presc_q;
        done_d   = 1'b0;
        tick_d   = 1'b0;
        if (load && (state_q == IDLE || state_q == DONE)) begin
            target_d = {clamp4(preset[15:12], MT_MAX), clamp4(preset[11:8], 4'd9),
                        clamp4(preset[7:4], 4'd5), clamp4(preset[3:0], 4'd9)};
            state_d  = IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    // A pausing cycle does not advance the prescaler, so
                    // every step costs exactly TICK_DIV advancing cycles.
                    if (pause) state_d = PAUSE;
                    else if (digits == terminal) begin
                        // Zero-length run: already at terminal on entry.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d  = '0;
                        digits_d = stepped;
                        tick_d   = 1'b1;
                        if (stepped == terminal) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                PAUSE: if (start) state_d = RUN;
                default: begin
                    if (start) begin
                        mode_d   = mode;
                        digits_d = mode ? 16'h0000 : target_q;
                        presc_d  = '0;
                        state_d  = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= IDLE;
            target_q <= 16'h0000;
            digits   <= 16'h0000;
            mode_q   <= 1'b0;
            presc_q  <= '0;
            running  <= 1'b0;
            paused   <= 1'b0;
            expired  <= 1'b0;
            done     <= 1'b0;
            sec_tick <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            digits   <= digits_d;
            mode_q   <= mode_d;
            presc_q  <= presc_d;
            running  <= (state_d == RUN);
            paused   <= (state_d == PAUSE);
            expired  <= (state_d == DONE);
            done     <= done_d;
            sec_tick <= tick_d;
        end
    end

endmodule

// File: tb/tb_irrigation_timer_mmss.sv
module tb_irrigation_timer_mmss;

    localparam int TD = 4;
    localparam int MT = 5;

    logic        clk = 1'b0;
    logic        clear, load, mode, start, pause;
    logic [15:0] preset;
    logic [15:0] digits;
    logic        running, paused, expired, done, sec_tick;

    int total = 0;
    int bad   = 0;

    irrigation_timer_mmss #(.TICK_DIV(TD), .MIN_TENS_MAX(MT)) dut (
        .clk(clk), .clear(clear), .load(load), .preset(preset), .mode(mode),
        .start(start), .pause(pause), .digits(digits), .running(running),
        .paused(paused), .expired(expired), .done(done), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    // Reference model: time kept as plain seconds, phase 0 idle / 1 run / 2 pause / 3 done.
    int m_phase = 0, m_cur = 0, m_tgt = 0, m_up = 0, m_elapsed = 0;
    bit m_done = 0, m_tick = 0;

    function automatic logic [15:0] to_bcd(input int s);
        int m, ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int preset_secs(input logic [15:0] p);
        int mt, mu, st, su;
        mt = (p[15:12] > MT) ? MT : int'(p[15:12]);
        mu = (p[11:8] > 9) ? 9 : int'(p[11:8]);
        st = (p[7:4] > 5) ? 5 : int'(p[7:4]);
        su = (p[3:0] > 9) ? 9 : int'(p[3:0]);
        return (mt * 10 + mu) * 60 + st * 10 + su;
    endfunction

    task automatic model_edge(input logic c, l, input logic [15:0] p, input logic md, s, pa);
        int term;
        m_done = 0;
        m_tick = 0;
        term = m_up ? m_tgt : 0;
        if (c) begin
            m_phase = 0; m_cur = 0; m_tgt = 0; m_up = 0; m_elapsed = 0;
        end else if (l && (m_phase == 0 || m_phase == 3)) begin
            m_tgt = preset_secs(p);
            m_phase = 0;
        end else if (m_phase == 1 && pa) begin
            m_phase = 2;
        end else if (s && m_phase == 2) begin
            m_phase = 1;
        end else if (s && (m_phase == 0 || m_phase == 3)) begin
            m_up = md;
            m_cur = md ? 0 : m_tgt;
            m_elapsed = 0;
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (m_cur == term) begin
                m_phase = 3; m_done = 1;
            end else begin
                m_elapsed++;
                if (m_elapsed == TD) begin
                    m_elapsed = 0;
                    m_cur = m_up ? m_cur + 1 : m_cur - 1;
                    m_tick = 1;
                    if (m_cur == term) begin
                        m_phase = 3; m_done = 1;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic c, l, input logic [15:0] p, input logic md, s, pa);
        clear = c; load = l; preset = p; mode = md; start = s; pause = pa;
        @(posedge clk);
        model_edge(c, l, p, md, s, pa);
        #1;
        clear = 0; load = 0; start = 0; pause = 0;
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 16'h0000, 0, 0, 0);
    endtask

    task automatic test_reset();
        cyc(1, 0, 16'h0000, 0, 0, 0);
        total++;
        if ({digits, running, paused, expired, done, sec_tick} !== 21'h0) begin
            bad++; $display("FAIL reset: got digits=%h flags=%b want 0000/00000", digits,
                            {running, paused, expired, done, sec_tick});
        end
    endtask

    task automatic test_countdown();
        cyc(0, 1, 16'h0012, 0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 1, 0);
        total++;
        if (digits !== 16'h0012 || running !== 1'b1) begin
            bad++; $display("FAIL cd_start: got %h run=%b want 0012 run=1", digits, running);
        end
        for (int s = 11; s >= 0; s--) begin
            for (int k = 0; k < TD - 1; k++) begin
                idle_cyc();
                total++;
                if (sec_tick !== 1'b0 || done !== 1'b0) begin
                    bad++; $display("FAIL cd_gap: got tick=%b done=%b want 0 0", sec_tick, done);
                end
            end
            idle_cyc();
            total++;
            if (sec_tick !== 1'b1 || digits !== to_bcd(s) || done !== (s == 0)) begin
                bad++; $display("FAIL cd_step: got %h tick=%b done=%b want %h tick=1 done=%0d",
                                digits, sec_tick, done, to_bcd(s), s == 0);
            end
        end
        idle_cyc();
        total++;
        if (done !== 1'b0 || expired !== 1'b1 || digits !== 16'h0000) begin
            bad++; $display("FAIL cd_hold: got done=%b exp=%b %h want 0 1 0000", done, expired, digits);
        end
    endtask

    task automatic test_back_to_back();
        cyc(0, 0, 16'h0000, 0, 1, 0);
        total++;
        if (digits !== 16'h0012 || running !== 1'b1 || expired !== 1'b0) begin
            bad++; $display("FAIL restart: got %h run=%b exp=%b want 0012 1 0", digits, running, expired);
        end
    endtask

    task automatic test_boundary();
        cyc(1, 0, 16'h0000, 0, 0, 0);
        cyc(0, 1, 16'h1000, 0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 1, 0);
        repeat (TD) idle_cyc();
        total++;
        if (digits !== 16'h0959) begin bad++; $display("FAIL borrow1: got %h want 0959", digits); end
        repeat (TD) idle_cyc();
        total++;
        if (digits !== 16'h0958) begin bad++; $display("FAIL borrow2: got %h want 0958", digits); end
        cyc(1, 0, 16'h0000, 0, 0, 0);
        cyc(0, 1, 16'h0101, 0, 0, 0);
        cyc(0, 0, 16'h0000, 1, 1, 0);
        total++;
        if (digits !== 16'h0000) begin bad++; $display("FAIL up_start: got %h want 0000", digits); end
        repeat (59 * TD) idle_cyc();
        total++;
        if (digits !== 16'h0059) begin bad++; $display("FAIL up_59: got %h want 0059", digits); end
        repeat (TD) idle_cyc();
        total++;
        if (digits !== 16'h0100 || done !== 1'b0) begin
            bad++; $display("FAIL carry: got %h done=%b want 0100 0", digits, done);
        end
        repeat (TD) idle_cyc();
        total++;
        if (digits !== 16'h0101 || done !== 1'b1 || expired !== 1'b1) begin
            bad++; $display("FAIL up_done: got %h done=%b exp=%b want 0101 1 1", digits, done, expired);
        end
    endtask

    task automatic test_clamp();
        cyc(0, 1, 16'hFA7C, 0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 1, 0);
        total++;
        if (digits !== 16'h5959) begin bad++; $display("FAIL clamp: got %h want 5959", digits); end
        repeat (TD) idle_cyc();
        total++;
        if (digits !== 16'h5958) begin bad++; $display("FAIL clamp_step: got %h want 5958", digits); end
    endtask

    task automatic test_pause();
        cyc(1, 0, 16'h0000, 0, 0, 0);
        cyc(0, 1, 16'h0030, 0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 1, 0);
        repeat (6) idle_cyc();
        total++;
        if (digits !== 16'h0029) begin bad++; $display("FAIL pre_pause: got %h want 0029", digits); end
        cyc(0, 0, 16'h0000, 0, 0, 1);
        total++;
        if (paused !== 1'b1 || running !== 1'b0) begin
            bad++; $display("FAIL pause: got p=%b r=%b want 1 0", paused, running);
        end
        for (int k = 0; k < 10; k++) begin
            cyc(0, 1, 16'h0005, 0, 0, 0);
            total++;
            if (paused !== 1'b1 || digits !== 16'h0029 || sec_tick !== 1'b0) begin
                bad++; $display("FAIL hold: got p=%b %h tick=%b want 1 0029 0", paused, digits, sec_tick);
            end
        end
        cyc(0, 0, 16'h0000, 0, 1, 0);
        idle_cyc();
        total++;
        if (running !== 1'b1 || sec_tick !== 1'b0) begin
            bad++; $display("FAIL resume1: got r=%b tick=%b want 1 0", running, sec_tick);
        end
        idle_cyc();
        total++;
        if (sec_tick !== 1'b1 || digits !== 16'h0028) begin
            bad++; $display("FAIL resume2: got tick=%b %h want 1 0028", sec_tick, digits);
        end
        cyc(0, 0, 16'h0000, 0, 1, 1);
        total++;
        if (paused !== 1'b1) begin bad++; $display("FAIL start_pause: got p=%b want 1", paused); end
    endtask

    task automatic test_zero();
        cyc(1, 0, 16'h0000, 0, 0, 0);
        cyc(0, 1, 16'h0000, 0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 1, 0);
        total++;
        if (running !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL zero_run: got r=%b d=%b want 1 0", running, done);
        end
        idle_cyc();
        total++;
        if (running !== 1'b0 || done !== 1'b1 || expired !== 1'b1 || sec_tick !== 1'b0) begin
            bad++; $display("FAIL zero_done: got r=%b d=%b e=%b t=%b want 0 1 1 0",
                            running, done, expired, sec_tick);
        end
        idle_cyc();
        total++;
        if (done !== 1'b0 || expired !== 1'b1) begin
            bad++; $display("FAIL zero_after: got d=%b e=%b want 0 1", done, expired);
        end
    endtask

    task automatic test_clear_midrun();
        cyc(0, 1, 16'h0007, 0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 1, 0);
        repeat (2 * TD) idle_cyc();
        total++;
        if (digits !== 16'h0005) begin bad++; $display("FAIL mid_val: got %h want 0005", digits); end
        cyc(1, 0, 16'h0000, 0, 0, 0);
        total++;
        if ({digits, running, paused, expired, done, sec_tick} !== 21'h0) begin
            bad++; $display("FAIL mid_clear: got %h %b want 0000 00000", digits,
                            {running, paused, expired, done, sec_tick});
        end
        repeat (TD) idle_cyc();
        total++;
        if (done !== 1'b0 || digits !== 16'h0000) begin
            bad++; $display("FAIL mid_after: got d=%b %h want 0 0000", done, digits);
        end
    endtask

    task automatic test_random();
        logic [15:0] p;
        cyc(1, 0, 16'h0000, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            p = ($urandom % 3 == 0) ? 16'($urandom) : {8'h00, 4'($urandom % 3), 4'($urandom % 10)};
            cyc(($urandom % 300) == 0, ($urandom % 20) == 0, p, 1'($urandom),
                ($urandom % 6) == 0, ($urandom % 25) == 0);
            total++;
            if ({digits, running, paused, expired, done, sec_tick} !==
                {to_bcd(m_cur), m_phase == 1, m_phase == 2, m_phase == 3, m_done, m_tick}) begin
                bad++; $display("FAIL rand@%0d: got %h %b want %h %b", k, digits,
                                {running, paused, expired, done, sec_tick}, to_bcd(m_cur),
                                {m_phase == 1, m_phase == 2, m_phase == 3, m_done, m_tick});
            end
        end
    endtask

    initial begin
        clear = 0; load = 0; preset = 16'h0; mode = 0; start = 0; pause = 0;
        @(negedge clk);
        test_reset();
        test_countdown();
        test_back_to_back();
        test_boundary();
        test_clamp();
        test_pause();
        test_zero();
        test_clear_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irrigation_timer_mmss.md
# irrigation_timer_mmss

- Parametrised four-digit BCD mm:ss timer for the irrigation controller; successor to the fixed single-digit minute/second counters.
- Adds the following:
  - an internal one-second prescaler;
  - selectable count-down (irrigation duration) or count-up (elapsed time against a target) mode;
  - run/pause/resume control and preset load;
  - a one-cycle completion pulse.
- Sits between the valve-control FSM, which issues load/start/pause and consumes `done`, and the seven-segment display path, which consumes `digits`.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: `clk` cycles per one-second step; minimum 2.
- `MIN_TENS_MAX`, default 5: largest tens-of-minutes digit; range 1..9.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `load`  in  1  capture `preset` into the target register.
- `preset`  in  16  packed BCD {min_t, min_u, sec_t, sec_u}.
- `mode`  in  1  0 = count down from target, 1 = count up from 00:00 to target; sampled at start from IDLE/DONE only.
- `start`  in  1  start, or resume from PAUSE.
- `pause`  in  1  suspend counting.
- `digits`  out  16  current value, packed BCD {min_t, min_u, sec_t, sec_u}.
- `running`  out  1  high in RUN.
- `paused`  out  1  high in PAUSE.
- `expired`  out  1  high in DONE.
- `done`  out  1  one-cycle pulse on entry to DONE.
- `sec_tick`  out  1  one-cycle pulse on every applied one-second step.

## Operation
States and transitions:
- IDLE:
  - `start` → RUN.
  - `load` → IDLE.
- RUN:
  - `pause` → PAUSE.
  - terminal value reached → DONE.
- PAUSE:
  - `start` → RUN.
- DONE:
  - `start` → RUN (fresh run).
  - `load` → IDLE.

Priority per cycle: `clear` > `load` > `pause` > `start`.
- `load` is honoured only in IDLE/DONE; ignored in RUN/PAUSE.
- `pause` is ignored outside RUN.

Preset sanitising at load: each digit is clamped to its maximum.
- sec_u, min_u: 9.
- sec_t: 5.
- min_t: `MIN_TENS_MAX`.

Fresh start (from IDLE or DONE):
- `mode` is latched.
- `digits` ← target in down mode, ← 0000 in up mode.
- Prescaler ← 0.

Resume from PAUSE keeps `digits`, the latched mode and the prescaler count.

Step in down mode (borrow chain):
- sec_u 0→9 borrows from sec_t.
- sec_t 0→5 borrows from min_u.
- min_u 0→9 borrows from min_t.

Step in up mode (carry chain):
- sec_u 9→0 carries.
- sec_t 5→0 carries.
- min_u 9→0 carries.
- min_t saturates at `MIN_TENS_MAX`.

Terminal value is 0000 in down mode, target in up mode.
- The step that produces the terminal value also moves the state to DONE and asserts `done` on the same edge.
- `digits` holds the terminal value in DONE.

Zero-length run: start when the initial value already equals the terminal value (target 00:00 in either mode).
- RUN is entered for exactly one cycle, then DONE with `done` pulsed.
- No `sec_tick` occurs.

## Timing
Reset values after `clear`:
- State IDLE.
- `digits` = 0000; target = 0000.
- `running` = `paused` = `expired` = `done` = `sec_tick` = 0.
- Prescaler = 0; mode = 0.

Reset mid-run takes effect on the next edge, with no final `done`.

Prescaler:
- Counts 0..`TICK_DIV`−1 only in RUN.
- The step and `sec_tick` are applied on the edge where the count wraps from `TICK_DIV`−1 to 0.
- First step after a fresh start therefore occurs `TICK_DIV` cycles after the start edge.

Outputs:
- All outputs are registered.
- `digits` updates on the same edge as `sec_tick`.
- `done` is high exactly one cycle.
- `expired` stays high until `start`, `load` or `clear`.

Pause/resume:
- A pause asserted in the same cycle as a wrap edge blocks that step.
- Total elapsed RUN cycles per step is always exactly `TICK_DIV`.

## Test plan
All scenarios use `TICK_DIV` = 4.
1. `clear`, then check idle outputs → `digits` = 0000 and all flags 0. Then load 16'h0012, start with mode 0 → `digits` 0012, 0011, 0010, 0009 … 0000 at 4-cycle spacing; `done` is a single pulse coincident with 0000; `expired` = 1.
2. Borrow/carry boundaries, mode 0 with target 1000 → steps 1000 → 0959 → 0958. Mode 1 with target 0101 → steps 0059 → 0100 → 0101 → `done`.
3. Preset clamping: load 16'hFA7C with `MIN_TENS_MAX` = 5 → target 5959.
4. Pause after 6 RUN cycles, hold 10 cycles, resume → next `sec_tick` exactly 2 RUN cycles after resume; no `digits` change during PAUSE; `load` during PAUSE ignored.
5. Zero-length run: load 0000, start → `running` for 1 cycle, then `done` pulse, no `sec_tick`.
6. Edge cases:
   - `clear` in RUN at 0005 → next cycle all reset values, no `done`.
   - `start`+`pause` same cycle in RUN → PAUSE.
   - `start` in DONE → fresh run from target.
